iagc_cmd_rx: RTL and testbench

//  Command-frame receiver feeding the IAGC control FSM. Consumes bytes from the UART RX

---
 rtl/iagc_pkg.sv | 20 ++
 rtl/iagc_cmd_timeout.sv | 32 +++
 rtl/iagc_cmd_rx.sv | 148 ++++++++++++++
 tb/tb_iagc_cmd_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/iagc_pkg.sv
// Shared IAGC definitions: FSM status codes, command opcodes, frame defaults.
// Used by iagc_cmd_rx and iagc_fsm.
package iagc_pkg;

   localparam int unsigned CMD_PARAM_SIZE_DEF = 4;
   localparam int unsigned CMD_BYTE_W         = 8;
   localparam logic [7:0]  SYNC_BYTE_DEF      = 8'hA5;

   // FSM status code reported while the control FSM waits for a command
   localparam logic [3:0]  STATUS_IDLE        = 4'b0010;

   // Opcode held on the command bus when no command has been accepted
   localparam logic [3:0]  CMD_EMPTY          = 4'h0;

   // Checksum byte closing a frame
   function automatic logic [7:0] frame_chk(input logic [7:0] sync_b, input logic [7:0] cmd_b);
      return sync_b ^ cmd_b;
   endfunction

endpackage

// File: rtl/iagc_cmd_timeout.sv
// Inter-byte timeout: loadable down-counter with terminal-count flag.
// o_tc_c is high in the cycle where the enabled count has run out, so the
// owner sees it TIMEOUT_CYCLES edges after the last load.
module iagc_cmd_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned TOUT_SIZE      = 17
)(
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_tc_c
);

   localparam logic [TOUT_SIZE-1:0] LOAD_VAL = TOUT_SIZE'(TIMEOUT_CYCLES - 1);

   logic [TOUT_SIZE-1:0] count;

   // Reload on every received byte, otherwise count down while enabled
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         count <= '0;
      end else if (i_load) begin
         count <= LOAD_VAL;
      end else if (i_en && (count != '0)) begin
         count <= count - TOUT_SIZE'(1);
      end
   end

   assign o_tc_c = i_en && (count == '0);

endmodule

// File: rtl/iagc_cmd_rx.sv
// Command-frame receiver for the IAGC control FSM.
// Frame: SYNC, CMD={op,param}[, CHK=SYNC^CMD]. The CHK byte is only expected
// when IAGC_CMD_CHECKSUM_EN is defined; otherwise frames are two bytes long.
module iagc_cmd_rx
   import iagc_pkg::*;
#(
   parameter int unsigned CMD_PARAM_SIZE = CMD_PARAM_SIZE_DEF,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned TOUT_SIZE      = 17,
   parameter int unsigned ERR_CNT_SIZE   = 8
)(
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic [7:0]                i_rx_data,
   input  logic                      i_rx_done,
   input  logic                      i_fsm_idle,
   output logic                      o_cmd_valid,
   output logic [CMD_PARAM_SIZE-1:0] o_cmd_operation,
   output logic [CMD_PARAM_SIZE-1:0] o_cmd_parameter,
   output logic                      o_frame_err,
   output logic [ERR_CNT_SIZE-1:0]   o_err_count,
   output logic                      o_busy
);

   localparam int unsigned CMD_W = 2 * CMD_PARAM_SIZE;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      WAIT_CMD  = 2'd1,
`ifdef IAGC_CMD_CHECKSUM_EN
      WAIT_CHK  = 2'd2,
`endif
      PENDING   = 2'd3
   } state_t;

   state_t                    state, state_n;
   logic [CMD_W-1:0]          cmd_buf, cmd_buf_n;
   logic                      valid_n;
   logic                      err_n;
   logic [CMD_PARAM_SIZE-1:0] op_n, par_n;
   logic                      tout_en_c;
   logic                      tout_tc_c;

   // Timeout runs only while a frame is partially received
`ifdef IAGC_CMD_CHECKSUM_EN
   assign tout_en_c = (state == WAIT_CMD) || (state == WAIT_CHK);
`else
   assign tout_en_c = (state == WAIT_CMD);
`endif

   iagc_cmd_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TOUT_SIZE      (TOUT_SIZE)
   ) u_timeout (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_load  (i_rx_done),
      .i_en    (tout_en_c),
      .o_tc_c  (tout_tc_c)
   );

   // State register and registered outputs
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state           <= WAIT_SYNC;
         cmd_buf         <= '0;
         o_cmd_valid     <= 1'b0;
         o_cmd_operation <= CMD_PARAM_SIZE'(CMD_EMPTY);
         o_cmd_parameter <= CMD_PARAM_SIZE'(CMD_EMPTY);
         o_frame_err     <= 1'b0;
         o_err_count     <= '0;
         o_busy          <= 1'b0;
      end else begin
         state           <= state_n;
         cmd_buf         <= cmd_buf_n;
         o_cmd_valid     <= valid_n;
         o_cmd_operation <= op_n;
         o_cmd_parameter <= par_n;
         o_frame_err     <= err_n;
         o_busy          <= (state_n != WAIT_SYNC);
         if (err_n && (o_err_count != '1)) begin
            o_err_count <= o_err_count + ERR_CNT_SIZE'(1);
         end
      end
   end

   // Next-state and output decode; a received byte beats a same-cycle timeout
   always_comb begin
      state_n   = state;
      cmd_buf_n = cmd_buf;
      valid_n   = 1'b0;
      err_n     = 1'b0;
      op_n      = o_cmd_operation;
      par_n     = o_cmd_parameter;
      case (state)
         WAIT_SYNC: begin
            if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
               state_n = WAIT_CMD;
            end
         end
         WAIT_CMD: begin
            if (i_rx_done) begin
               cmd_buf_n = CMD_W'(i_rx_data);
`ifdef IAGC_CMD_CHECKSUM_EN
               state_n   = WAIT_CHK;
`else
               state_n   = PENDING;
`endif
            end else if (tout_tc_c) begin
               err_n   = 1'b1;
               state_n = WAIT_SYNC;
            end
         end
`ifdef IAGC_CMD_CHECKSUM_EN
         WAIT_CHK: begin
            if (i_rx_done) begin
               if (i_rx_data == frame_chk(SYNC_BYTE, 8'(cmd_buf))) begin
                  state_n = PENDING;
               end else begin
                  err_n   = 1'b1;
                  state_n = WAIT_SYNC;
               end
            end else if (tout_tc_c) begin
               err_n   = 1'b1;
               state_n = WAIT_SYNC;
            end
         end
`endif
         PENDING: begin
            if (i_fsm_idle) begin
               valid_n = 1'b1;
               op_n    = cmd_buf[CMD_W-1 -: CMD_PARAM_SIZE];
               par_n   = cmd_buf[CMD_PARAM_SIZE-1:0];
               state_n = WAIT_SYNC;
            end
            // Byte arriving while a command waits is an overrun; it is dropped
            if (i_rx_done) begin
               err_n = 1'b1;
            end
         end
         default: begin
            state_n = WAIT_SYNC;
         end
      endcase
   end

endmodule

// File: tb/tb_iagc_cmd_rx.sv
// Directed bench for iagc_cmd_rx (TIMEOUT_CYCLES=20). Follows IAGC_CMD_CHECKSUM_EN
// to choose between 3-byte and 2-byte frames.
module tb_iagc_cmd_rx;

`ifdef IAGC_CMD_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       idle;
   logic       cmd_valid;
   logic [3:0] cmd_op;
   logic [3:0] cmd_par;
   logic       frame_err;
   logic [7:0] err_count;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int n_err    = 0;
   int valid_cyc = -1;
   int err_cyc   = -1;
   int last_rx_cyc = 0;

   iagc_cmd_rx #(
      .CMD_PARAM_SIZE (4),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (20),
      .TOUT_SIZE      (17),
      .ERR_CNT_SIZE   (8)
   ) dut (
      .i_clock         (clk),
      .i_reset         (rst),
      .i_rx_data       (rx_data),
      .i_rx_done       (rx_done),
      .i_fsm_idle      (idle),
      .o_cmd_valid     (cmd_valid),
      .o_cmd_operation (cmd_op),
      .o_cmd_parameter (cmd_par),
      .o_frame_err     (frame_err),
      .o_err_count     (err_count),
      .o_busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Count strobes away from the active edge
   always @(negedge clk) begin
      if (cmd_valid) begin
         n_valid   <= n_valid + 1;
         valid_cyc <= cyc;
      end
      if (frame_err) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data     = b;
      rx_done     = 1'b1;
      last_rx_cyc = cyc;
      @(negedge clk);
      rx_done     = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] chk);
      send_byte(8'hA5);
      send_byte(cmd);
      if (CHK_EN) send_byte(chk);
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int v0, e0, rise_cyc, a5_cyc;

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; idle = 1'b1;
      settle(3);
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_op",    32'(cmd_op),    32'd0);
      check("rst_par",   32'(cmd_par),   32'd0);
      check("rst_err",   32'(frame_err), 32'd0);
      check("rst_errcnt",32'(err_count), 32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      rst = 1'b0;
      settle(2);

      // 1: good frame, latency 2 edges after last byte
      v0 = n_valid;
      send_frame(8'h35, 8'h90);
      settle(2);
      check("t1_nvalid",  32'(n_valid - v0),           32'd1);
      check("t1_latency", 32'(valid_cyc - last_rx_cyc), 32'd2);
      check("t1_op",      32'(cmd_op),    32'd3);
      check("t1_par",     32'(cmd_par),   32'd5);
      check("t1_errcnt",  32'(err_count), 32'd0);
      check("t1_busy",    32'(busy),      32'd0);
      settle(3);
      check("t1_op_hold", 32'(cmd_op),    32'd3);

      // 2: bad checksum (3-byte build) / noise bytes ignored before sync
      if (CHK_EN) begin
         v0 = n_valid; e0 = n_err;
         send_frame(8'h35, 8'h91);
         settle(3);
         check("t2_nerr",   32'(n_err - e0),   32'd1);
         check("t2_nvalid", 32'(n_valid - v0), 32'd0);
         check("t2_errcnt", 32'(err_count),    32'd1);
         check("t2_op",     32'(cmd_op),       32'd3);
         check("t2_par",    32'(cmd_par),      32'd5);
      end
      v0 = n_valid; e0 = n_err;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_frame(8'h46, 8'hE3);
      settle(3);
      check("noise_nvalid", 32'(n_valid - v0), 32'd1);
      check("noise_nerr",   32'(n_err - e0),   32'd0);
      check("noise_op",     32'(cmd_op),       32'd4);
      check("noise_par",    32'(cmd_par),      32'd6);

      // 3: timeout 20 edges after the sync byte, then recovery
      e0 = n_err;
      send_byte(8'hA5);
      settle(25);
      check("t3_nerr",    32'(n_err - e0),            32'd1);
      check("t3_err_at",  32'(err_cyc - last_rx_cyc), 32'd21);
      check("t3_busy",    32'(busy),                  32'd0);
      check("t3_errcnt",  32'(err_count),             CHK_EN ? 32'd2 : 32'd1);
      send_frame(8'h72, 8'hD7);
      settle(3);
      check("t3_op",  32'(cmd_op),  32'd7);
      check("t3_par", 32'(cmd_par), 32'd2);

      // Byte landing on the terminal-count cycle wins over the timeout
      e0 = n_err; v0 = n_valid;
      send_byte(8'hA5);
      a5_cyc = last_rx_cyc;
      while (cyc < a5_cyc + 19) @(negedge clk);
      send_byte(8'h5C);
      if (CHK_EN) send_byte(8'hF9);
      settle(3);
      check("tc_nerr",   32'(n_err - e0),   32'd0);
      check("tc_nvalid", 32'(n_valid - v0), 32'd1);
      check("tc_op",     32'(cmd_op),       32'h5);
      check("tc_par",    32'(cmd_par),      32'hC);

      // 4: FSM busy, command waits; overrun byte flagged but command kept
      idle = 1'b0;
      v0 = n_valid; e0 = n_err;
      send_frame(8'h81, 8'h24);
      settle(10);
      check("t4_busy",    32'(busy),          32'd1);
      check("t4_nvalid0", 32'(n_valid - v0),  32'd0);
      send_byte(8'h00);
      settle(2);
      check("t4_overrun", 32'(n_err - e0),    32'd1);
      settle(36);
      @(negedge clk);
      idle = 1'b1;
      rise_cyc = cyc;
      settle(2);
      check("t4_nvalid",  32'(n_valid - v0),        32'd1);
      check("t4_latency", 32'(valid_cyc - rise_cyc), 32'd1);
      check("t4_op",      32'(cmd_op),  32'd8);
      check("t4_par",     32'(cmd_par), 32'd1);

      // Idle rising together with a byte: issue and overrun in the same cycle
      idle = 1'b0;
      v0 = n_valid; e0 = n_err;
      send_frame(8'h6E, 8'hCB);
      settle(3);
      @(negedge clk);
      idle = 1'b1; rx_data = 8'h00; rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      settle(2);
      check("sim_nvalid", 32'(n_valid - v0), 32'd1);
      check("sim_nerr",   32'(n_err - e0),   32'd1);
      check("sim_op",     32'(cmd_op),       32'h6);
      check("sim_par",    32'(cmd_par),      32'hE);

      // 5: error counter saturates at 255
      if (CHK_EN) begin
         for (int i = 0; i < 300; i++) send_frame(8'h35, 8'h91);
      end else begin
         idle = 1'b0;
         send_frame(8'h35, 8'h90);
         for (int i = 0; i < 300; i++) send_byte(8'h00);
         idle = 1'b1;
      end
      settle(3);
      check("t5_sat", 32'(err_count), 32'd255);

      // Reset in the middle of a frame
      send_byte(8'hA5);
      if (CHK_EN) send_byte(8'h35);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_op",     32'(cmd_op),    32'd0);
      check("mrst_par",    32'(cmd_par),   32'd0);
      check("mrst_errcnt", 32'(err_count), 32'd0);
      check("mrst_busy",   32'(busy),      32'd0);
      check("mrst_valid",  32'(cmd_valid), 32'd0);
      rst = 1'b0;
      v0 = n_valid;
      send_frame(8'h46, 8'hE3);
      settle(3);
      check("mrst_nvalid", 32'(n_valid - v0), 32'd1);
      check("mrst_op2",    32'(cmd_op),       32'd4);
      check("mrst_par2",   32'(cmd_par),      32'd6);
      check("mrst_errcnt2",32'(err_count),    32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
